// File: rtl/sindoku_board_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sindoku_board_ctrl
// Brief    : Arbiter/sequencer for the Sindoku board RAM and the puzzle and
//            solution ROMs: cursor display reads, user edits, solution scan.
//            Optional first-error capture: define SINDOKU_FIRST_ERR_EN.
// Revision : 1.0  initial release
// ============================================================================
module sindoku_board_ctrl #(
  parameter int GRID    = 9,
  parameter int N_CELLS = 81,
  parameter int AW      = 7,
  parameter int DW      = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Ack,
  input  logic          Wr_req,
  input  logic [3:0]    Row,
  input  logic [3:0]    Col,
  input  logic [DW-1:0] userIn,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] solu_rdata,
  input  logic          given_rdata,
  output logic [DW-1:0] disp_ij,
  output logic          Wr_rej,
  output logic          q_I,
  output logic          q_Solve,
  output logic          q_Check,
  output logic          q_Correct,
  output logic          q_Incorrect,
`ifdef SINDOKU_FIRST_ERR_EN
  output logic [3:0]    err_row,
  output logic [3:0]    err_col,
`endif
  output logic [6:0]    err_cnt
);

  typedef enum logic [2:0] {
    ST_INI       = 3'd0,
    ST_SOLVE     = 3'd1,
    ST_WCHK      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_CORRECT   = 3'd6,
    ST_INCORRECT = 3'd7
  } state_t;

  localparam logic [3:0]    c_MAX_RC   = 4'(GRID - 1);
  localparam logic [DW-1:0] c_MAX_VAL  = DW'(GRID);
  localparam logic [AW-1:0] c_LAST_K   = AW'(N_CELLS - 1);

  state_t        r_state;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_edit_addr;
  logic [DW-1:0] r_edit_val;
  logic          r_cmp_vld;
  logic          r_disp_rd;

  logic [AW:0]   w_row_ext;
  logic [AW:0]   w_col_ext;
  logic [AW:0]   w_cur_sum;
  logic [AW-1:0] w_cur_addr;
  logic          w_edit_ok;
  logic          w_mismatch;
  logic [6:0]    w_err_nxt;

  // Row*9 + Col as (Row<<3) + Row + Col
  assign w_row_ext  = {{(AW-3){1'b0}}, Row};
  assign w_col_ext  = {{(AW-3){1'b0}}, Col};
  assign w_cur_sum  = (w_row_ext << 3) + w_row_ext + w_col_ext;
  assign w_cur_addr = w_cur_sum[AW-1:0];

  assign w_edit_ok  = (Row <= c_MAX_RC) && (Col <= c_MAX_RC) && (userIn <= c_MAX_VAL);
  assign w_mismatch = r_cmp_vld && ((mem_rdata == '0) || (mem_rdata != solu_rdata));
  assign w_err_nxt  = err_cnt + 7'(w_mismatch);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_INI;
      r_k         <= '0;
      r_edit_addr <= '0;
      r_edit_val  <= '0;
      r_cmp_vld   <= 1'b0;
      r_disp_rd   <= 1'b0;
      disp_ij     <= '0;
      Wr_rej      <= 1'b0;
      err_cnt     <= '0;
    end else begin
      r_cmp_vld <= (r_state == ST_CHECK);
      r_disp_rd <= (r_state == ST_SOLVE) || (r_state == ST_CORRECT) ||
                   (r_state == ST_INCORRECT);
      // Edits are only accepted from idle; anywhere else they bounce at once
      Wr_rej    <= Wr_req && (r_state != ST_SOLVE);
      if (r_disp_rd) disp_ij <= mem_rdata;
      if (r_cmp_vld) err_cnt <= w_err_nxt;

      case (r_state)
        ST_INI: r_state <= ST_SOLVE;
        ST_SOLVE: begin
          if (Start) begin
            r_state <= ST_CHECK;
            r_k     <= '0;
            err_cnt <= '0;
            Wr_rej  <= Wr_req;
          end else if (Wr_req) begin
            if (w_edit_ok) begin
              r_edit_addr <= w_cur_addr;
              r_edit_val  <= userIn;
              r_state     <= ST_WCHK;
            end else begin
              Wr_rej <= 1'b1;
            end
          end
        end
        ST_WCHK: r_state <= ST_WRITE;
        ST_WRITE: begin
          Wr_rej  <= Wr_req || given_rdata;
          r_state <= ST_SOLVE;
        end
        ST_CHECK: begin
          if (r_k == c_LAST_K) r_state <= ST_DRAIN;
          else                 r_k     <= r_k + AW'(1);
        end
        ST_DRAIN: r_state <= (w_err_nxt == '0) ? ST_CORRECT : ST_INCORRECT;
        ST_CORRECT, ST_INCORRECT: begin
          if (Ack) r_state <= ST_SOLVE;
        end
        default: r_state <= ST_INI;
      endcase
    end
  end

  // Address mux and write strobe; decoded from the state register so a reset
  // removes the strobe without waiting for a clock edge.
  always_comb begin
    mem_addr  = w_cur_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      ST_INI:   mem_addr = '0;
      ST_WCHK:  mem_addr = r_edit_addr;
      ST_WRITE: begin
        mem_addr  = r_edit_addr;
        mem_we    = !given_rdata;
        mem_wdata = r_edit_val;
      end
      ST_CHECK: mem_addr = r_k;
      default:  mem_addr = w_cur_addr;
    endcase
  end

  assign q_I         = (r_state == ST_INI);
  assign q_Solve     = (r_state == ST_SOLVE);
  assign q_Check     = (r_state == ST_WCHK) || (r_state == ST_WRITE) ||
                       (r_state == ST_CHECK) || (r_state == ST_DRAIN);
  assign q_Correct   = (r_state == ST_CORRECT);
  assign q_Incorrect = (r_state == ST_INCORRECT);

`ifdef SINDOKU_FIRST_ERR_EN
  logic [3:0] r_scan_row;
  logic [3:0] r_scan_col;
  logic [3:0] r_cmp_row;
  logic [3:0] r_cmp_col;

  // Row/column counters track r_k, delayed one cycle to line up with the compare
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_scan_row <= '0;
      r_scan_col <= '0;
      r_cmp_row  <= '0;
      r_cmp_col  <= '0;
      err_row    <= 4'hF;
      err_col    <= 4'hF;
    end else begin
      r_cmp_row <= r_scan_row;
      r_cmp_col <= r_scan_col;
      if ((r_state == ST_SOLVE) && Start) begin
        r_scan_row <= '0;
        r_scan_col <= '0;
        err_row    <= 4'hF;
        err_col    <= 4'hF;
      end else if (r_state == ST_CHECK) begin
        if (r_scan_col == c_MAX_RC) begin
          r_scan_col <= '0;
          r_scan_row <= r_scan_row + 4'd1;
        end else begin
          r_scan_col <= r_scan_col + 4'd1;
        end
      end
      if (w_mismatch && (err_cnt == '0)) begin
        err_row <= r_cmp_row;
        err_col <= r_cmp_col;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sindoku_board_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sindoku_board_ctrl
// Brief    : Directed self-checking bench with board RAM / ROM models.
// Revision : 1.0  initial release
// ============================================================================
module tb_sindoku_board_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Ack = 1'b0;
  logic       Wr_req = 1'b0;
  logic [3:0] Row = 4'd2;
  logic [3:0] Col = 4'd3;
  logic [3:0] userIn = 4'd5;
  logic [6:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic [3:0] solu_rdata;
  logic       given_rdata;
  logic [3:0] disp_ij;
  logic       Wr_rej;
  logic       q_I, q_Solve, q_Check, q_Correct, q_Incorrect;
  logic [6:0] err_cnt;
`ifdef SINDOKU_FIRST_ERR_EN
  logic [3:0] err_row, err_col;
`endif

  logic [3:0] ram [0:127];
  logic [3:0] sol [0:127];
  logic       giv [0:127];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_writes = 0;
  int         w0;

  always #5 Clk = ~Clk;

  sindoku_board_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Wr_req(Wr_req),
    .Row(Row), .Col(Col), .userIn(userIn),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .solu_rdata(solu_rdata), .given_rdata(given_rdata),
    .disp_ij(disp_ij), .Wr_rej(Wr_rej),
    .q_I(q_I), .q_Solve(q_Solve), .q_Check(q_Check),
    .q_Correct(q_Correct), .q_Incorrect(q_Incorrect),
`ifdef SINDOKU_FIRST_ERR_EN
    .err_row(err_row), .err_col(err_col),
`endif
    .err_cnt(err_cnt)
  );

  // Registered-read memories, one-cycle latency
  always @(posedge Clk) begin
    mem_rdata   <= ram[mem_addr];
    solu_rdata  <= sol[mem_addr];
    given_rdata <= giv[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      n_writes      <= n_writes + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic bad_edit(input logic [3:0] r, input logic [3:0] c, input logic [3:0] v);
    w0 = n_writes;
    Row = r; Col = c; userIn = v;
    Wr_req = 1'b1;
    tick(1);
    Wr_req = 1'b0;
    check_val("bad_edit_rej", Wr_rej, 1);
    check_val("bad_edit_state", q_Solve, 1);
    tick(3);
    check_val("bad_edit_nowrite", n_writes, w0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      sol[i] = (i < 81) ? 4'((i % 9) + 1) : 4'd0;
      ram[i] = sol[i];
      giv[i] = 1'b0;
    end
    giv[30] = 1'b1;

    // Reset state
    tick(2);
    check_val("rst_q_I", q_I, 1);
    check_val("rst_q_Solve", q_Solve, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_err_cnt", err_cnt, 0);
    check_val("rst_disp", disp_ij, 0);
    check_val("rst_wr_rej", Wr_rej, 0);
    #2 Reset = 1'b1;
    tick(1);
    check_val("ini_to_solve", q_Solve, 1);
    check_val("cursor_addr", mem_addr, 21);

    // Valid edit on a non-given cell: addr 2*9+3 = 21
    Wr_req = 1'b1;
    tick(1);
    Wr_req = 1'b0;
    check_val("wchk_q_check", q_Check, 1);
    check_val("wchk_addr", mem_addr, 21);
    check_val("wchk_we", mem_we, 0);
    tick(1);
    check_val("write_we", mem_we, 1);
    check_val("write_addr", mem_addr, 21);
    check_val("write_data", mem_wdata, 5);
    tick(1);
    check_val("ram21", ram[21], 5);
    check_val("edit_no_rej", Wr_rej, 0);
    check_val("edit_back_solve", q_Solve, 1);
    tick(2);
    check_val("disp_after_edit", disp_ij, 5);

    // Refused edits: value out of range, row out of range
    bad_edit(4'd2, 4'd3, 4'd10);
    bad_edit(4'd9, 4'd3, 4'd5);

    // Edit of a given cell (addr 30)
    w0 = n_writes;
    Row = 4'd3; Col = 4'd3; userIn = 4'd7;
    Wr_req = 1'b1;
    tick(1);
    Wr_req = 1'b0;
    tick(1);
    check_val("given_no_we", mem_we, 0);
    tick(1);
    check_val("given_rej", Wr_rej, 1);
    check_val("given_ram", ram[30], 4);
    check_val("given_nowrite", n_writes, w0);

    // Board equals solution
    ram[21] = 4'd4;
    Row = 4'd2; Col = 4'd3;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    check_val("scan_q_check", q_Check, 1);
    check_val("scan_k0", mem_addr, 0);
    tick(81);
    check_val("drain_q_check", q_Check, 1);
    check_val("drain_not_done", q_Correct, 0);
    tick(1);
    check_val("correct_at_82", q_Correct, 1);
    check_val("correct_err_cnt", err_cnt, 0);
`ifdef SINDOKU_FIRST_ERR_EN
    check_val("correct_err_row", err_row, 4'hF);
    check_val("correct_err_col", err_col, 4'hF);
`endif
    tick(2);
    check_val("correct_holds", q_Correct, 1);
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    check_val("ack_to_solve", q_Solve, 1);

    // Cells 4 and 80 empty, edit attempt mid-scan
    ram[4] = 4'd0;
    ram[80] = 4'd0;
    w0 = n_writes;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(9);
    Wr_req = 1'b1;
    tick(1);
    Wr_req = 1'b0;
    check_val("scan_rej", Wr_rej, 1);
    check_val("scan_still", q_Check, 1);
    tick(72);
    check_val("incorrect", q_Incorrect, 1);
    check_val("incorrect_err_cnt", err_cnt, 2);
    check_val("scan_nowrite", n_writes, w0);
`ifdef SINDOKU_FIRST_ERR_EN
    check_val("first_err_row", err_row, 0);
    check_val("first_err_col", err_col, 4);
`endif
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    check_val("inc_ack_solve", q_Solve, 1);
    check_val("err_cnt_holds", err_cnt, 2);

    // Start and Wr_req together, then reset at k=40
    Start = 1'b1;
    Wr_req = 1'b1;
    tick(1);
    Start = 1'b0;
    Wr_req = 1'b0;
    check_val("both_check", q_Check, 1);
    check_val("both_rej", Wr_rej, 1);
    check_val("both_err_clr", err_cnt, 0);
    check_val("both_no_we", mem_we, 0);
    tick(40);
    check_val("scan_k40", mem_addr, 40);
    check_val("k40_err_cnt", err_cnt, 1);
    #2 Reset = 1'b0;
    #1;
    check_val("async_q_I", q_I, 1);
    check_val("async_we", mem_we, 0);
    check_val("async_err_cnt", err_cnt, 0);
    check_val("async_addr", mem_addr, 0);
    check_val("async_q_check", q_Check, 0);
    check_val("abort_nowrite", n_writes, w0);
    #2 Reset = 1'b1;
    tick(1);
    check_val("rerelease_solve", q_Solve, 1);

    // Ack held high: result state lasts one cycle
    ram[4] = 4'd5;
    ram[80] = 4'd9;
    Ack = 1'b1;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(82);
    check_val("ack_lvl_correct", q_Correct, 1);
    tick(1);
    check_val("ack_lvl_solve", q_Solve, 1);
    Ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
